pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and PC-sequencing controller for the pipelined MIPS core. It produces the next-PC value and the hold signal for the PC register, and the hold, flush and bubble controls for the IF/ID and ID/EX pipeline registers. It covers three cases:
- load-use stalls;
- EX-stage redirects (taken branch, jump, jr);
- fixed-latency multiply/divide occupancy, which needs an internal countdown FSM.

It sits between the decode/execute stage logic and the PC register and pipeline registers.

## Interface
Parameters:
- N, 32, PC/address width
- REG_W, 5, register-index width
- MC_CYCLES, 4, number of cycles the mult/div unit occupies after issue (allowed range 2..63)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- pc_value  in  N  current PC from the PC register
- redirect_valid  in  1  EX stage resolved a taken branch or jump this cycle
- redirect_target  in  N  target address for the redirect
- id_rs  in  REG_W  rs field of the instruction in ID
- id_rt  in  REG_W  rt field of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt as a source
- id_mc_start  in  1  instruction in ID is mult/multu/div/divu
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_W  destination register of the load in EX
- new_pc  out  N  next PC, fed to the PC register
- hazard_flag  out  1  PC hold; 1 = the PC register keeps its value
- ifid_hold  out  1  IF/ID register keeps its contents
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_bubble  out  1  ID/EX register loads a NOP (control zeroed)
- mc_busy  out  1  mult/div unit occupied
- stall_cycles  out  32  saturating stall counter; present only when the configuration macro is defined

## Operation
- Next PC: new_pc = redirect_target when redirect_valid, else pc_value + 4 (modulo 2^N).
- Load-use hazard (lu): ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- FSM states: IDLE and MC_WAIT. The 6-bit down-counter mc_cnt is used only in MC_WAIT.
- Priority, highest first: redirect > MC_WAIT stall > lu > mc issue.
- Redirect, in any state:
  - outputs: ifid_flush=1, idex_bubble=1, hazard_flag=0, ifid_hold=0;
  - an id_mc_start in the same cycle is discarded and no MC_WAIT entry occurs;
  - the FSM state and counter continue unaffected.
- MC_WAIT without redirect: hazard_flag=1, ifid_hold=1, idex_bubble=1. The lu condition is ignored because it is already stalled.
- IDLE with lu and no redirect: hazard_flag=1, ifid_hold=1, idex_bubble=1 for exactly that cycle.
- IDLE with id_mc_start, no lu and no redirect:
  - the mult/div instruction advances to EX normally this cycle;
  - next state is MC_WAIT with mc_cnt = MC_CYCLES-1.
- MC_WAIT behaviour:
  - mc_cnt decrements each cycle;
  - when mc_cnt==1, next state is IDLE;
  - total stall = MC_CYCLES-1 cycles after issue.
- mc_busy = (state == MC_WAIT).
- ifid_flush and ifid_hold are never both 1; flush wins.

## Timing
- All stall, flush and new_pc outputs are combinational from the inputs and registered state, valid in the same cycle. The FSM and counter update on rising clk.
- Reset, asynchronous: state=IDLE, mc_cnt=0, stall_cycles=0.
- While reset is low:
  - hazard_flag=0, ifid_hold=0, mc_busy=0;
  - ifid_flush and idex_bubble follow redirect_valid;
  - new_pc follows its combinational equation.
- Reset asserted mid-MC_WAIT aborts the wait immediately; the first cycle after release is IDLE.
- Back-to-back mult/div: a second id_mc_start arriving during MC_WAIT is held in ID. It issues in the first IDLE cycle and re-enters MC_WAIT on the next edge.
- Redirect arriving during MC_WAIT is honoured, but the stall still runs to completion.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cycles increments on every rising edge where hazard_flag==1 and reset is high;
  - it saturates at 32'hFFFF_FFFF.
- HAZARD_STATS_EN undefined: the stall_cycles port and counter are absent, and the block has no other difference.

## Structure
- Shared package pipe_hazard_pkg holds:
  - the state enum (IDLE, MC_WAIT);
  - the PC increment constant 4;
  - the reset PC 32'h0040_0000, for use by the bench.
- One sub-module, hazard_mc_timer, contains the MC_WAIT FSM and the down-counter, with inputs issue and outputs busy.
- Hazard detection and next-PC muxing stay in the top module.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → one cycle of hazard_flag=1, ifid_hold=1, idex_bubble=1; outputs return to 0 the next cycle. Repeat with ex_rt=0 → no stall.
- Redirect: pc_value=0x0040_0010, redirect_valid=1, redirect_target=0x0040_0100 → new_pc=0x0040_0100, ifid_flush=1, idex_bubble=1, hazard_flag=0.
- Mult/div: MC_CYCLES=4, id_mc_start=1 for one cycle → mc_busy=1 and hazard_flag=1 for exactly 3 cycles, then IDLE with new_pc=pc_value+4.
- Priority: id_mc_start=1 together with redirect_valid=1 → flush only, mc_busy stays 0. Separately, lu together with id_mc_start → one lu stall cycle, then mult/div issue.
- Reset: assert reset low during the 2nd MC_WAIT cycle → mc_busy=0 and hazard_flag=0 immediately; IDLE after release.
- Statistics (HAZARD_STATS_EN defined): lu stall (1 cycle) plus mult/div with MC_CYCLES=4 (3 cycles) → stall_cycles=4.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard / PC-sequencing controller.
package pipe_hazard_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MC_WAIT = 1'b1
    } mc_state_e;

    localparam logic [31:0] PC_INCR  = 32'd4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/pipe_hazard_if.sv
// Bundle of decode/execute-side inputs and pipeline-control outputs of pipe_hazard_ctrl.
interface pipe_hazard_if #(
    parameter int N     = 32,
    parameter int REG_W = 5
);
    logic [N-1:0]     pc_value;
    logic             redirect_valid;
    logic [N-1:0]     redirect_target;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_mc_start;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic [N-1:0]     new_pc;
    logic             hazard_flag;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             mc_busy;

    modport master (
        output pc_value, redirect_valid, redirect_target, id_rs, id_rt,
               id_uses_rt, id_mc_start, ex_mem_read, ex_rt,
        input  new_pc, hazard_flag, ifid_hold, ifid_flush, idex_bubble, mc_busy
    );

    modport slave (
        input  pc_value, redirect_valid, redirect_target, id_rs, id_rt,
               id_uses_rt, id_mc_start, ex_mem_read, ex_rt,
        output new_pc, hazard_flag, ifid_hold, ifid_flush, idex_bubble, mc_busy
    );
endinterface

// File: rtl/hazard_mc_timer.sv
// Mult/div occupancy FSM: after an issue it stays busy for MC_CYCLES-1 cycles.
module hazard_mc_timer
    import pipe_hazard_pkg::*;
#(
    parameter int MC_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic busy
);

    mc_state_e  state, state_nxt;
    logic [5:0] mc_cnt, mc_cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt  = MC_WAIT;
                    mc_cnt_nxt = 6'(MC_CYCLES - 1);
                end
            end
            MC_WAIT: begin
                mc_cnt_nxt = mc_cnt - 6'd1;
                if (mc_cnt == 6'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == MC_WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and next-PC controller: load-use stalls, EX redirects, mult/div occupancy.
// Defining HAZARD_STATS_EN adds the saturating stall_cycles counter port.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int N         = 32,
    parameter int REG_W     = 5,
    parameter int MC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    pipe_hazard_if.slave hz
);

    logic lu;
    logic stall;
    logic mc_issue;
    logic mc_busy_int;

    // Load-use: a load in EX writes a register the ID instruction reads.
    assign lu = reset && hz.ex_mem_read && (hz.ex_rt != '0) &&
                ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // A redirect overrides every stall; a mult/div only issues when nothing holds ID.
    assign stall    = !hz.redirect_valid && (mc_busy_int || lu);
    assign mc_issue = reset && !hz.redirect_valid && !mc_busy_int && !lu && hz.id_mc_start;

    hazard_mc_timer #(
        .MC_CYCLES (MC_CYCLES)
    ) u_mc_timer (
        .clk   (clk),
        .reset (reset),
        .issue (mc_issue),
        .busy  (mc_busy_int)
    );

    assign hz.new_pc      = hz.redirect_valid ? hz.redirect_target : hz.pc_value + N'(PC_INCR);
    assign hz.hazard_flag = stall;
    assign hz.ifid_hold   = stall;
    assign hz.ifid_flush  = hz.redirect_valid;
    assign hz.idex_bubble = hz.redirect_valid || stall;
    assign hz.mc_busy     = mc_busy_int;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_pkg::*;

    localparam int MC_CYCLES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_if #(.N(32), .REG_W(5)) hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    pipe_hazard_ctrl #(
        .N         (32),
        .REG_W     (5),
        .MC_CYCLES (MC_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .hz           (hz)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          rem   = 0;      // model: cycles of mult/div occupancy still to come
    logic [31:0] stats_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        hz.pc_value        = RESET_PC;
        hz.redirect_valid  = 1'b0;
        hz.redirect_target = '0;
        hz.id_rs           = '0;
        hz.id_rt           = '0;
        hz.id_uses_rt      = 1'b0;
        hz.id_mc_start     = 1'b0;
        hz.ex_mem_read     = 1'b0;
        hz.ex_rt           = '0;
    endtask

    task automatic rand_inputs();
        hz.pc_value        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
        hz.redirect_valid  = ($urandom_range(0, 7) == 0);
        hz.redirect_target = $urandom;
        hz.id_rs           = 5'($urandom_range(0, 3));
        hz.id_rt           = 5'($urandom_range(0, 3));
        hz.id_uses_rt      = 1'($urandom);
        hz.id_mc_start     = ($urandom_range(0, 3) == 0);
        hz.ex_mem_read     = ($urandom_range(0, 2) == 0);
        hz.ex_rt           = 5'($urandom_range(0, 3));
    endtask

    // Called just after a falling edge with inputs already driven; ends on the next falling edge.
    task automatic cycle();
        logic        lu, redir, stall, issue;
        logic [31:0] npc;
        #1;
        if (!rst_n) begin
            rem     = 0;
            stats_m = '0;
        end
        redir = hz.redirect_valid;
        lu    = rst_n && hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
        stall = rst_n && !redir && ((rem > 0) || lu);
        issue = rst_n && !redir && (rem == 0) && !lu && hz.id_mc_start;
        npc   = redir ? hz.redirect_target : hz.pc_value + 32'd4;

        chk("new_pc",      hz.new_pc,      npc);
        chk("hazard_flag", 32'(hz.hazard_flag), 32'(stall));
        chk("ifid_hold",   32'(hz.ifid_hold),   32'(stall));
        chk("ifid_flush",  32'(hz.ifid_flush),  32'(redir));
        chk("idex_bubble", 32'(hz.idex_bubble), 32'(redir || stall));
        chk("mc_busy",     32'(hz.mc_busy),     32'(rem > 0));
`ifdef HAZARD_STATS_EN
        chk("stall_cycles", stall_cycles, stats_m);
`endif
        @(posedge clk);
        if (rst_n) begin
            if (stall && (stats_m != 32'hFFFF_FFFF)) stats_m = stats_m + 32'd1;
            if (rem > 0)    rem = rem - 1;
            else if (issue) rem = MC_CYCLES - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);

        // Reset held: no stalls, flush/bubble follow redirect, lu ignored.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
        cycle();
        chk("rst_hazard", 32'(hz.hazard_flag), 32'd0);
        hz.redirect_valid = 1'b1; hz.redirect_target = 32'h0000_1000;
        cycle();
        clear_inputs();
        rst_n = 1'b1;
        cycle();

        // Load-use stall for one cycle, then clear; ex_rt=0 never stalls.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
        #1 chk("lu_hazard", 32'(hz.hazard_flag), 32'd1);
        cycle();
        clear_inputs();
        cycle();
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
        #1 chk("lu_r0", 32'(hz.hazard_flag), 32'd0);
        cycle();
        clear_inputs();

        // Redirect.
        hz.pc_value = 32'h0040_0010; hz.redirect_valid = 1'b1; hz.redirect_target = 32'h0040_0100;
        #1 chk("redir_pc", hz.new_pc, 32'h0040_0100);
        cycle();
        clear_inputs();

        // Mult/div occupancy: issue, 3 busy cycles, then idle.
        hz.id_mc_start = 1'b1;
        cycle();
        hz.id_mc_start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("mc_done", 32'(hz.mc_busy), 32'd0);

        // Redirect discards a simultaneous issue.
        hz.id_mc_start = 1'b1; hz.redirect_valid = 1'b1; hz.redirect_target = 32'h0040_0200;
        cycle();
        clear_inputs();
        #1 chk("redir_mc", 32'(hz.mc_busy), 32'd0);
        cycle();

        // lu together with mc start: one lu stall, then issue.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd3; hz.id_rt = 5'd3; hz.id_uses_rt = 1'b1; hz.id_mc_start = 1'b1;
        cycle();
        hz.ex_mem_read = 1'b0;
        cycle();
        hz.id_mc_start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Reset during the 2nd MC_WAIT cycle aborts the wait.
        hz.id_mc_start = 1'b1;
        cycle();
        hz.id_mc_start = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1 chk("rst_abort_busy", 32'(hz.mc_busy), 32'd0);
        chk("rst_abort_hazard", 32'(hz.hazard_flag), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Stall statistics: one lu stall plus a full mult/div occupancy.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.id_mc_start = 1'b1;
        cycle();
        hz.ex_mem_read = 1'b0;
        cycle();
        hz.id_mc_start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
`ifdef HAZARD_STATS_EN
        chk("stats_total", stall_cycles, 32'd4);
`endif

        // PC wrap.
        hz.pc_value = 32'hFFFF_FFFC;
        #1 chk("pc_wrap", hz.new_pc, 32'h0000_0000);
        cycle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
